counter_arbiter_ctrl: RTL and testbench

//   Shares one loadable N-bit up-counter between two requesters.

---
 rtl/counter_arbiter_ctrl_if.sv | 21 ++
 rtl/counter_arbiter_ctrl.sv | 63 ++++++
 tb/tb_counter_arbiter_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/counter_arbiter_ctrl_if.sv
// counter_arbiter_ctrl_if: requester and counter-side signals of the shared counter arbiter
interface counter_arbiter_ctrl_if #(parameter int N = 4);
    logic [1:0]   req;
    logic [N-1:0] start0;
    logic [N-1:0] start1;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         busy;
    logic         cnt_load;
    logic [N-1:0] cnt_init;
    logic         cnt_en;
    logic [N-1:0] cnt_value;
    modport master (
        output req, start0, start1, cnt_value,
        input  gnt, done, busy, cnt_load, cnt_init, cnt_en
    );
    modport slave (
        input  req, start0, start1, cnt_value,
        output gnt, done, busy, cnt_load, cnt_init, cnt_en
    );
endinterface

// File: rtl/counter_arbiter_ctrl.sv
// counter_arbiter_ctrl: round-robin sharing of one external up-counter between two requesters
module counter_arbiter_ctrl #(parameter int N = 4) (
    input logic clk,
    input logic rst,
    counter_arbiter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam logic [N-1:0] TERM = '1;
    state_t       state_q, state_d;
    logic [1:0]   gnt_q, gnt_d;
    logic         last_q, last_d;
    logic [N-1:0] cnt_init_q, cnt_init_d;
    logic         pick, g, req_g, at_term;
    assign g       = gnt_q[1];
    assign req_g   = bus.req[g];
    assign at_term = bus.cnt_value == TERM;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_q     <= 1'b1;
            cnt_init_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cnt_init_q <= cnt_init_d;
        end
    end
    // on a tie requester 1 wins only when requester 0 was served last
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_init_d = cnt_init_q;
        pick       = bus.req[1] & (~bus.req[0] | ~last_q);
        case (state_q)
            IDLE: if (|bus.req) begin
                gnt_d      = pick ? 2'b10 : 2'b01;
                cnt_init_d = pick ? bus.start1 : bus.start0;
                state_d    = LOAD;
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (!req_g) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (at_term) state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                last_d  = g;
            end
        endcase
    end
    assign bus.gnt      = gnt_q;
    assign bus.done     = (state_q == DONE) ? gnt_q : 2'b00;
    assign bus.busy     = state_q != IDLE;
    assign bus.cnt_load = state_q == LOAD;
    assign bus.cnt_init = cnt_init_q;
    assign bus.cnt_en   = (state_q == RUN) && req_g && !at_term;
endmodule

// File: tb/tb_counter_arbiter_ctrl.sv
// tb_counter_arbiter_ctrl: directed vectors plus corner sequences against a behavioural counter
module tb_counter_arbiter_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    counter_arbiter_ctrl_if #(.N(4)) bus ();
    counter_arbiter_ctrl #(.N(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // the external counter the block controls
    always_ff @(posedge clk) begin
        if (rst) bus.cnt_value <= '0;
        else if (bus.cnt_load) bus.cnt_value <= bus.cnt_init;
        else if (bus.cnt_en) bus.cnt_value <= bus.cnt_value + 4'd1;
    end
    typedef struct {
        logic [1:0] req;
        logic [3:0] s0;
        logic [3:0] s1;
        logic       chg;
        logic [1:0] g;
        logic [3:0] init;
        int         en;
        int         lat;
    } vec_t;
    vec_t vecs [7];
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic run_one(input vec_t v);
        int k_done = 0, loads = 0, ens = 0, ovl = 0, g1 = 0, i1 = 0, dv = 0, cv = 0, ci = 0;
        @(negedge clk);
        bus.req = v.req;
        bus.start0 = v.s0;
        bus.start1 = v.s1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 3 && v.chg) bus.start0 = 4'd0;
            if (k == 1) begin
                g1 = int'(bus.gnt);
                i1 = int'(bus.cnt_init);
            end
            loads += int'(bus.cnt_load);
            ens += int'(bus.cnt_en);
            if (bus.cnt_load && bus.cnt_en) ovl++;
            if (|bus.done) begin
                k_done = k;
                dv = int'(bus.done);
                cv = int'(bus.cnt_value);
                ci = int'(bus.cnt_init);
                break;
            end
        end
        bus.req = 2'b00;
        chk("gnt_at_t1", g1, int'(v.g));
        chk("init_at_t1", i1, int'(v.init));
        chk("load_cycles", loads, 1);
        chk("en_cycles", ens, v.en);
        chk("done_latency", k_done, v.lat);
        chk("done_bit", dv, int'(v.g));
        chk("value_at_done", cv, 15);
        chk("init_at_done", ci, int'(v.init));
        chk("load_en_overlap", ovl, 0);
        tick();
        chk("idle_after_done", int'({bus.busy, bus.gnt, bus.done}), 0);
    endtask
    initial begin
        int got [3];
        int n, dsum;
        vecs[0] = '{2'b01, 4'd9,  4'd0,  1'b0, 2'b01, 4'd9,  6,  9};
        vecs[1] = '{2'b10, 4'd0,  4'd15, 1'b0, 2'b10, 4'd15, 0,  3};
        vecs[2] = '{2'b10, 4'd0,  4'd3,  1'b0, 2'b10, 4'd3,  12, 15};
        vecs[3] = '{2'b01, 4'd0,  4'd0,  1'b0, 2'b01, 4'd0,  15, 18};
        vecs[4] = '{2'b11, 4'd5,  4'd14, 1'b0, 2'b10, 4'd14, 1,  4};
        vecs[5] = '{2'b11, 4'd7,  4'd2,  1'b0, 2'b01, 4'd7,  8,  11};
        vecs[6] = '{2'b01, 4'd3,  4'd0,  1'b1, 2'b01, 4'd3,  12, 15};
        bus.req = 2'b00;
        bus.start0 = 4'd0;
        bus.start1 = 4'd0;
        tick();
        tick();
        chk("reset_gnt", int'(bus.gnt), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_load_en", int'({bus.cnt_load, bus.cnt_en}), 0);
        chk("reset_init", int'(bus.cnt_init), 0);
        rst = 1'b0;
        foreach (vecs[i]) run_one(vecs[i]);
        // both requesters held from reset: grants alternate starting with 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 2'b11;
        bus.start0 = 4'd13;
        bus.start1 = 4'd14;
        n = 0;
        for (int k = 0; k < 80 && n < 3; k++) begin
            logic [1:0] prev;
            prev = bus.gnt;
            tick();
            if (prev == 2'b00 && bus.gnt != 2'b00) begin
                got[n] = int'(bus.gnt);
                n++;
            end
        end
        chk("alt_count", n, 3);
        chk("alt_gnt0", got[0], 1);
        chk("alt_gnt1", got[1], 2);
        chk("alt_gnt2", got[2], 1);
        bus.req = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // abort: requester 1 drops its request mid-run
        bus.req = 2'b10;
        bus.start1 = 4'd3;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.busy && bus.cnt_value == 4'd6) begin
                n = 1;
                break;
            end
        end
        chk("abort_reached_6", n, 1);
        bus.req = 2'b00;
        #1;
        chk("abort_en_same_cycle", int'(bus.cnt_en), 0);
        dsum = 0;
        tick();
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_gnt", int'(bus.gnt), 0);
        chk("abort_value_held", int'(bus.cnt_value), 6);
        dsum += int'(bus.done);
        for (int k = 0; k < 4; k++) begin
            tick();
            dsum += int'(bus.done);
        end
        chk("abort_no_done", dsum, 0);
        // reset in the middle of a run
        bus.req = 2'b01;
        bus.start0 = 4'd3;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.busy && bus.cnt_value == 4'd10) begin
                n = 1;
                break;
            end
        end
        chk("rst_reached_10", n, 1);
        rst = 1'b1;
        tick();
        chk("midrst_state", int'({bus.busy, bus.gnt, bus.done}), 0);
        chk("midrst_load_en", int'({bus.cnt_load, bus.cnt_en}), 0);
        chk("midrst_init", int'(bus.cnt_init), 0);
        bus.req = 2'b00;
        rst = 1'b0;
        run_one('{2'b01, 4'd12, 4'd0, 1'b0, 2'b01, 4'd12, 3, 6});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
